// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 signed convolution over a raster-order pixel
// stream. Two line buffers hold the previous rows, a 3x3 window is formed on
// each accepted pixel, and one saturated result is emitted per strided window.
// Optional feature macro: CONV2D_RELU_EN (fused ReLU on the saturated result).
module conv2d_stream #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 20,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int LAST_C = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;
  localparam int LAST_R = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;
  localparam int PW     = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PW + 4;
  localparam int EXT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic                      r_last_done;
  logic signed [COEF_W-1:0]  r_coef [9];
  logic [DATA_W-1:0]         r_lb_top [IMG_W];
  logic [DATA_W-1:0]         r_lb_mid [IMG_W];
  logic [DATA_W-1:0]         r_wa [3];
  logic [DATA_W-1:0]         r_wb [3];

  logic                      w_acc;
  logic                      w_col_last;
  logic                      w_row_last;
  logic                      w_win_vld;
  logic                      w_win_last;
  logic                      w_out_hs_last;
  logic [DATA_W-1:0]         w_tap [9];
  logic signed [PW-1:0]      w_pa;
  logic signed [PW-1:0]      w_pb;
  logic signed [PW-1:0]      w_prod;
  logic signed [SUM_W-1:0]   w_sum;

  // Clamp the full-width sum into the signed output range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
    logic signed [EXT_W-1:0] x;
    x = EXT_W'(v);
    if (x > SAT_MAX)      return SAT_MAX[ACC_W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[ACC_W-1:0];
    else                  return x[ACC_W-1:0];
  endfunction

  // Optional rectification of the saturated result.
  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef CONV2D_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign pix_ready     = (r_state == S_RUN) && (!out_valid || out_ready);
  assign busy          = (r_state != S_IDLE);
  assign w_acc         = pix_valid && pix_ready;
  assign w_out_hs_last = out_valid && out_ready && out_last;
  assign w_col_last    = (r_col == CW'(IMG_W - 1));
  assign w_row_last    = (r_row == RW'(IMG_H - 1));
  assign w_win_vld     = (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                         (((int'(r_row) - 2) % STRIDE) == 0) &&
                         (((int'(r_col) - 2) % STRIDE) == 0);
  assign w_win_last    = w_win_vld && (r_row == RW'(LAST_R)) && (r_col == CW'(LAST_C));

  // Assemble the window as it stands once the incoming pixel is shifted in.
  always_comb begin
    w_tap[0] = r_wa[0];
    w_tap[1] = r_wb[0];
    w_tap[2] = r_lb_top[r_col];
    w_tap[3] = r_wa[1];
    w_tap[4] = r_wb[1];
    w_tap[5] = r_lb_mid[r_col];
    w_tap[6] = r_wa[2];
    w_tap[7] = r_wb[2];
    w_tap[8] = pix_data;
  end

  // Nine signed products summed at full width (pixels zero-extended).
  always_comb begin
    w_sum  = '0;
    w_pa   = '0;
    w_pb   = '0;
    w_prod = '0;
    for (int k = 0; k < 9; k++) begin
      w_pa   = PW'(signed'({1'b0, w_tap[k]}));
      w_pb   = PW'(r_coef[k]);
      w_prod = w_pa * w_pb;
      w_sum  = w_sum + SUM_W'(w_prod);
    end
  end

  // Frame sequencing: IDLE -> RUN -> FLUSH -> IDLE with a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      done        <= 1'b0;
      r_last_done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_out_hs_last) r_last_done <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_last_done <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_acc && w_col_last && w_row_last) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          // Trailing pixels may let the final result drain before FLUSH.
          if (w_out_hs_last || r_last_done) begin
            r_state <= S_IDLE;
            done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Kernel register file, writable only while idle; addresses 9..15 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) r_coef[k] <= '0;
    end else if (r_state == S_IDLE && coef_we && coef_addr < 4'd9) begin
      r_coef[coef_addr] <= signed'(coef_data);
    end
  end

  // Line buffers and window columns shift on every accepted pixel (not reset).
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb_top[r_col] <= r_lb_mid[r_col];
      r_lb_mid[r_col] <= pix_data;
      for (int i = 0; i < 3; i++) r_wa[i] <= r_wb[i];
      r_wb[0] <= r_lb_top[r_col];
      r_wb[1] <= r_lb_mid[r_col];
      r_wb[2] <= pix_data;
    end
  end

  // Output register: load on a completed valid window, hold until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (w_acc && w_win_vld) begin
      out_valid <= 1'b1;
      out_data  <= relu(sat_acc(w_sum));
      out_last  <= w_win_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Scoreboard bench for conv2d_stream: random frames are convolved by a plain
// arithmetic reference model, expected results are queued at frame start, and
// an independent monitor pops and compares each accepted output.
`timescale 1ns/1ps
module tb_conv2d_stream;

  localparam int IMG_W  = 7;
  localparam int IMG_H  = 6;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 16;
  localparam int STRIDE = 2;
  localparam int OW     = (IMG_W - 3) / STRIDE + 1;
  localparam int OH     = (IMG_H - 3) / STRIDE + 1;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam longint SMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (ACC_W - 1));

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic                     coef_we;
  logic [3:0]               coef_addr;
  logic [COEF_W-1:0]        coef_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [DATA_W-1:0]        pix_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;
  logic                     busy;
  logic                     done;

  conv2d_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W),
    .COEF_W(COEF_W), .ACC_W(ACC_W), .STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint d; bit l; } exp_t;
  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     coef_m[9];
  int     img[NPIX];
  bit     chk_en = 1'b1;
  int     ready_mode = 0;
  bit     prev_stall = 1'b0;
  longint prev_d;
  bit     prev_l;

  function automatic void chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Direct cross-correlation of one output window from the stored image.
  function automatic longint model_px(int oy, int ox);
    longint s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        s += longint'(coef_m[3*ky+kx]) * longint'(img[(oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx]);
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`ifdef CONV2D_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic push_frame();
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        sb.push_back('{model_px(oy, ox), (oy == OH-1) && (ox == OW-1)});
  endtask

  task automatic gen_image(input int pmode);
    for (int i = 0; i < NPIX; i++)
      case (pmode)
        1:       img[i] = 255;
        2:       img[i] = i % 256;
        default: img[i] = int'($urandom_range(0, 255));
      endcase
  endtask

  function automatic int coef_val(input int cmode, input int k);
    case (cmode)
      1:       return int'($urandom_range(0, 8)) - 4;
      2:       return (k == 4) ? 1 : 0;
      3:       return -1;
      4:       return 127;
      5:       return -128;
      6:       return 1;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  // Kernel load while idle; the final write shares its cycle with start.
  task automatic load_and_start(input int cmode, input bit load);
    @(negedge clk); #2;
    coef_we = 1'b1; coef_addr = 4'(9 + $urandom_range(0, 6)); coef_data = COEF_W'($urandom);
    if (load) begin
      for (int k = 0; k < 9; k++) begin
        int v;
        v = coef_val(cmode, k);
        @(negedge clk); #2;
        coef_we = 1'b1; coef_addr = 4'(k); coef_data = COEF_W'(v);
        coef_m[k] = v;
        start = (k == 8);
      end
    end else begin
      @(negedge clk); #2;
      coef_we = 1'b0; start = 1'b1;
    end
    @(negedge clk); #2;
    coef_we = 1'b0; start = 1'b0;
    chk("busy_run", busy, 1);
  endtask

  task automatic feed(input int npix, input bit poke);
    int idx = 0;
    int budget = 0;
    while (idx < npix && budget < 5000) begin
      @(negedge clk); #2;
      budget++;
      coef_we = 1'b0;
      start   = 1'b0;
      if (poke && idx == 3) begin
        coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'h4d;
      end
      if (poke && idx == 5) start = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_data  = DATA_W'(img[idx]);
        if (pix_ready) idx++;
      end
    end
    @(negedge clk); #2;
    pix_valid = 1'b0; coef_we = 1'b0; start = 1'b0;
    chk("pixels_fed", idx, npix);
  endtask

  task automatic run_frame(input int cmode, input int pmode, input bit load, input bit poke);
    int w = 0;
    gen_image(pmode);
    load_and_start(cmode, load);
    push_frame();
    feed(NPIX, poke);
    while (!done && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    chk("done_seen", done, 1);
    chk("sb_empty", sb.size(), 0);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_last"},  out_last, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
  endtask

  // Monitor: drive out_ready, verify stall stability, pop on every handshake.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en && prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
        chk("hold_last", out_last, prev_l);
      end
      prev_stall = 1'b0;
      out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      if (chk_en && out_valid) begin
        if (!out_ready) begin
          chk("stall_pix_ready", pix_ready, 0);
          prev_stall = 1'b1;
          prev_d = out_data;
          prev_l = out_last;
        end else if (sb.size() == 0) begin
          chk("unexpected_output", out_data, 0);
          n_fail += (out_data == 0) ? 1 : 0;
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; pix_valid = 1'b0; pix_data = '0;
    for (int k = 0; k < 9; k++) coef_m[k] = 0;
    #23;
    check_reset_vals("rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("post_rst");

    ready_mode = 0;
    run_frame(6, 2, 1'b1, 1'b0);
    run_frame(2, 0, 1'b1, 1'b0);
    ready_mode = 1;
    run_frame(3, 1, 1'b1, 1'b0);
    run_frame(4, 1, 1'b1, 1'b0);
    run_frame(5, 1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_frame(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) run_frame(1, 0, 1'b1, 1'b0);

    // Mid-frame reset: discard the partial frame, kernel returns to zero.
    chk_en = 1'b0;
    gen_image(0);
    load_and_start(0, 1'b1);
    feed(20, 1'b0);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    for (int k = 0; k < 9; k++) coef_m[k] = 0;
    @(negedge clk); #1;
    chk_en = 1'b1;
    run_frame(0, 0, 1'b0, 1'b0);

    ready_mode = 0;
    run_frame(0, 0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming 3x3 convolution engine: the parametrised successor to the fixed-window conv layer. Consumes a raster-order pixel stream of one IMG_W x IMG_H channel, holds two rows in internal line buffers, applies a runtime-loadable signed 3x3 kernel at a configurable stride, and emits one saturated result per valid window. Sits between the image loader and the pooling/dense stages of the MNIST classifier; several instances are chained to form multiple conv layers.

## Interface
- IMG_W, 28, image width in pixels (>=3)
- IMG_H, 28, image height in pixels (>=3)
- DATA_W, 8, unsigned pixel width
- COEF_W, 8, signed two's-complement kernel coefficient width
- ACC_W, 20, signed output width; internal sum saturates to this width
- STRIDE, 1, window step in x and y (1..4)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse in IDLE begins a frame
- coef_we  in  1  kernel write strobe; honoured only in IDLE
- coef_addr  in  4  kernel index k = 3*row + col, 0..8; 9..15 ignored
- coef_data  in  COEF_W  coefficient value
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  input pixel accepted when valid && ready
- pix_data  in  DATA_W  pixel, raster order, row 0 first
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  signed convolution result
- out_last  out  1  high with final result of the frame
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when final result is accepted

## Operation
- Reset values: pix_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0; all nine coefficients=0; counters=0; state=IDLE. Line-buffer contents are not reset.
- States: IDLE -> (start) RUN -> (last pixel accepted) FLUSH -> (last result accepted) IDLE with done pulse. start outside IDLE is ignored.
- Pixel counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel; col wraps to 0 and increments row.
- Two line buffers of IMG_W x DATA_W plus a 3x3 window register shift on each accepted pixel.
- Window is valid when row>=2, col>=2, (row-2)%STRIDE==0 and (col-2)%STRIDE==0. Output grid is ((IMG_W-3)/STRIDE+1) x ((IMG_H-3)/STRIDE+1); trailing pixels that complete no window are consumed silently.
- Arithmetic: pixel zero-extended to DATA_W+1 signed; nine products summed at full width DATA_W+COEF_W+5; result saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Kernel orientation: k=0 multiplies the oldest (top-left) window pixel, k=8 the newest (bottom-right). No kernel flip (cross-correlation).
- coef_we while busy is dropped. coef_we and start in the same IDLE cycle: write takes effect, frame starts.
- out_last asserted with the result of the bottom-right output window.

## Timing
- pix_ready = (state==RUN) && (!out_valid || out_ready).
- Latency: out_valid rises the cycle after the pixel completing a valid window is accepted; out_data/out_last held stable while out_valid && !out_ready.
- Sustained throughput with out_ready=1: one pixel per cycle.
- FLUSH: pix_ready=0; leaves when out_valid && out_ready && out_last; done pulses that cycle-plus-one, state IDLE same cycle.
- rst_n low mid-frame: immediate return to reset values; partial frame discarded; next frame requires start.

## Configuration
- CONV2D_RELU_EN defined: negative saturated results are replaced by 0 before out_data (ReLU fused). Undefined: raw signed saturated result output.

## Test plan
- IMG_W=IMG_H=5, coef[4]=1 others 0, pixels 0..24 -> outputs 6,7,8,11,12,13,16,17,18; out_last with 18; done pulse after.
- Same image, all coefs 1 -> first output 54, last output 162.
- All coefs -1, all pixels 255 -> -2295 without CONV2D_RELU_EN, 0 with it.
- ACC_W=10, all coefs 127, all pixels 255 -> every output saturates to 511.
- STRIDE=2, 5x5, coef[4]=1 -> exactly four outputs 6,8,16,18.
- Hold out_ready low 3 cycles during RUN -> pix_ready low, out_data stable; rst_n low mid-frame -> all outputs return to reset values, busy=0.
